// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: frames a program image into imem,
// verifies an XOR checksum, then releases the processor.
module imem_boot_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              proc_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state;
  logic [7:0]          len_hi;
  logic [ADDR_W:0]     n_words;
  logic [23:0]         shift;
  logic [1:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [7:0]          chk;

  logic                accept;
  logic                in_frame;
  logic [15:0]         n_raw;
  logic                n_bad;
  logic [ADDR_W:0]     wl_next;

  always_comb begin
    in_frame = 1'b0;
    case (state)
      S_LEN_HI,
      S_LEN_LO,
      S_PAYLOAD,
      S_CHECK: in_frame = 1'b1;
      default: in_frame = 1'b0;
    endcase
  end

  assign in_ready = in_frame && !restart;
  assign accept   = in_valid && in_ready;
  assign n_raw    = {len_hi, in_data};
  assign n_bad    = (n_raw == 16'd0) ||
                    ({1'b0, n_raw} > CAP);
  assign wl_next  = words_loaded + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_LEN_HI;
      len_hi       <= '0;
      n_words      <= '0;
      shift        <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      chk          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      proc_run     <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        // Already-written words stay in imem; proc_run=0 keeps them idle
        state        <= S_LEN_HI;
        byte_cnt     <= '0;
        word_idx     <= '0;
        chk          <= '0;
        words_loaded <= '0;
        proc_run     <= 1'b0;
        load_err     <= 1'b0;
      end else if (accept) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            if (n_bad) begin
              state    <= S_ERROR;
              load_err <= 1'b1;
            end else begin
              n_words  <= n_raw[ADDR_W:0];
              byte_cnt <= '0;
              word_idx <= '0;
              chk      <= '0;
              state    <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            shift    <= {shift[15:0], in_data};
            chk      <= chk ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= word_idx;
              imem_wdata   <= {shift, in_data};
              word_idx     <= word_idx + 1'b1;
              words_loaded <= wl_next;
              if (wl_next == n_words) begin
                state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (in_data == chk) begin
              state    <= S_DONE;
              proc_run <= 1'b1;
            end else begin
              state    <= S_ERROR;
              load_err <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed vector bench for imem_boot_loader.
// Table of per-cycle vectors plus a gapped 3-word frame.
module tb_imem_boot_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          restart;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          proc_run;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .restart      (restart),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .proc_run     (proc_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        restart;
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        run;
    logic        err;
    logic [6:0]  wl;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] W = 32'h2008_0005;

  function automatic void add(
    input logic r, input logic rs, input logic v,
    input logic [7:0] d, input logic rdy,
    input logic we, input logic [5:0] a,
    input logic [31:0] wd, input logic run,
    input logic err, input logic [6:0] wl);
    vec_t t;
    t.rst_n = r; t.restart = rs; t.valid = v;
    t.data = d; t.rdy = rdy; t.we = we; t.addr = a;
    t.wdata = wd; t.run = run; t.err = err; t.wl = wl;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rs,
                       input logic v, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; restart = rs; in_valid = v; in_data = d;
  endtask

  int wr_n = 0;
  logic [5:0]  wr_a[$];
  logic [31:0] wr_d[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      wr_n++;
      wr_a.push_back(imem_addr);
      wr_d.push_back(imem_wdata);
    end
  end

  initial begin
    rst_n = 1'b0; restart = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_run", 32'(proc_run), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);

    // good single-word frame, CHK=2D
    add(1,0,1,8'h00, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h01, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h20, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h08, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h05, 1, 1,0,W,0,0,1);
    add(1,0,1,8'h2D, 1, 0,0,W,1,0,1);
    add(1,0,1,8'h55, 0, 0,0,W,1,0,1);
    add(1,1,1,8'h00, 0, 0,0,W,0,0,0);
    // bad checksum
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h01, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h20, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h08, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h05, 1, 1,0,W,0,0,1);
    add(1,0,1,8'h2C, 1, 0,0,W,0,1,1);
    add(1,0,1,8'h77, 0, 0,0,W,0,1,1);
    add(1,1,0,8'h00, 0, 0,0,W,0,0,0);
    // zero length
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,W,0,1,0);
    add(1,0,1,8'h12, 0, 0,0,W,0,1,0);
    add(1,1,0,8'h00, 0, 0,0,W,0,0,0);
    // length 65
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h41, 1, 0,0,W,0,1,0);
    add(1,0,1,8'h00, 0, 0,0,W,0,1,0);
    add(1,1,0,8'h00, 0, 0,0,W,0,0,0);
    // restart mid-word, then fresh frame
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h02, 1, 0,0,W,0,0,0);
    add(1,0,1,8'hAA, 1, 0,0,W,0,0,0);
    add(1,0,1,8'hBB, 1, 0,0,W,0,0,0);
    add(1,1,1,8'hCC, 0, 0,0,W,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h01, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h20, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h08, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,W,0,0,0);
    add(1,0,1,8'h05, 1, 1,0,W,0,0,1);
    add(1,0,1,8'h2D, 1, 0,0,W,1,0,1);
    // reset while done, reset beats restart
    add(0,1,1,8'h00, 0, 0,0,0,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h01, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h20, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h08, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h00, 1, 0,0,0,0,0,0);
    add(1,0,1,8'h05, 1, 1,0,W,0,0,1);
    add(1,0,1,8'h2D, 1, 0,0,W,1,0,1);

    foreach (vecs[i]) begin
      vec_t t;
      t = vecs[i];
      drive(t.rst_n, t.restart, t.valid, t.data);
      #1;
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(t.rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i), 32'(imem_we), 32'(t.we));
      check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(t.addr));
      check($sformatf("v%0d_wdata", i), imem_wdata, t.wdata);
      check($sformatf("v%0d_run", i), 32'(proc_run), 32'(t.run));
      check($sformatf("v%0d_err", i), 32'(load_err), 32'(t.err));
      check($sformatf("v%0d_wl", i), 32'(words_loaded), 32'(t.wl));
    end

    // three-word frame with random valid gaps
    drive(1, 1, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    wr_n = 0;
    wr_a.delete();
    wr_d.delete();
    begin
      logic [7:0] bytes[$];
      bytes = '{8'h00, 8'h03,
                8'h11, 8'h11, 8'h11, 8'h11,
                8'h22, 8'h22, 8'h22, 8'h22,
                8'h33, 8'h33, 8'h33, 8'h33,
                8'h00};
      foreach (bytes[k]) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) drive(1, 0, 0, 8'hEE);
        drive(1, 0, 1, bytes[k]);
      end
    end
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    #1;
    check("t2_writes", 32'(wr_n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < wr_a.size()) begin
        check($sformatf("t2_addr%0d", k),
              32'(wr_a[k]), 32'(k));
        check($sformatf("t2_data%0d", k),
              wr_d[k], {4{8'(8'h11 * (k + 1))}});
      end
    end
    check("t2_run", 32'(proc_run), 32'd1);
    check("t2_err", 32'(load_err), 32'd0);
    check("t2_wl", 32'(words_loaded), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
